// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN link blocks: sample width, BER
// measurement state encoding and QPSK bit ordering.
package awgn_pkg;

  localparam int BI = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ber_state_t;

  // Position of each rail inside a 2-bit QPSK symbol.
  localparam int QPSK_I_BIT = 0;
  localparam int QPSK_Q_BIT = 1;

endpackage

// File: rtl/qpsk_slicer_ber_if.sv
// Data-path bundle of the QPSK slicer / BER counter.
//
// Handshake rules: a reference pair is taken on a rising edge where
// ref_valid=1 and ref_ready=1; ref_valid while ref_ready=0 loses the pair.
// sample_valid has no back-pressure: the sample is consumed or discarded on
// the edge it is presented. dec_valid is a one-cycle pulse qualifying
// dec_bits and is never stalled.
interface qpsk_slicer_ber_if #(
  parameter int BI = awgn_pkg::BI
);
  logic                 ref_valid;
  logic [1:0]           ref_bits;
  logic                 ref_ready;
  logic                 sample_valid;
  logic signed [BI-1:0] y_real;
  logic signed [BI-1:0] y_imag;
  logic                 dec_valid;
  logic [1:0]           dec_bits;

  modport master (
    output ref_valid, ref_bits, sample_valid, y_real, y_imag,
    input  ref_ready, dec_valid, dec_bits
  );

  modport slave (
    input  ref_valid, ref_bits, sample_valid, y_real, y_imag,
    output ref_ready, dec_valid, dec_bits
  );
endinterface

// File: rtl/qpsk_slicer_ber_ref_bit_fifo.sv
// Synchronous FIFO for transmitted reference bit pairs. No bypass: a word
// pushed on an edge is only readable after that edge.
module ref_bit_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [1:0]  push_data,
  input  logic        pop,
  output logic [1:0]  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/qpsk_slicer_ber.sv
// Hard-decision QPSK slicer with bit-error counting over one measurement
// run of NUM_SYMBOLS symbols. Reference bits are queued ahead of samples.
module qpsk_slicer_ber
  import awgn_pkg::*;
#(
  parameter int NUM_SYMBOLS = 320000,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  qpsk_slicer_ber_if.slave   bus,
  output logic [CNT_W-1:0]   sym_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy,
  output logic               done,
  output logic               underflow,
  output logic               overflow,
  output ber_state_t         state_dbg
);
  localparam int               FAW       = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0]     DEPTH_C   = (FAW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] NUM_SYM_C = CNT_W'(NUM_SYMBOLS);
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;

  ber_state_t     state_q, state_d;
  logic           fifo_full, fifo_empty;
  logic [1:0]     fifo_head;
  logic [FAW:0]   fifo_count;
  logic           run_start, accept, take, starve, push_drop;
  logic [1:0]     sliced, err_bits, err_inc;
  logic [CNT_W:0] err_sum;
  logic [CNT_W-1:0] sym_next;
  logic           dec_valid_q;
  logic [1:0]     dec_bits_q;

  ref_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.ref_valid),
    .push_data (bus.ref_bits),
    .pop       (take),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Negative samples decide 1; zero and positive decide 0.
  assign sliced[QPSK_I_BIT] = ($signed(bus.y_real) < 0);
  assign sliced[QPSK_Q_BIT] = ($signed(bus.y_imag) < 0);

  assign run_start = start && (state_q != RUN);
  assign accept    = (state_q == RUN) && bus.sample_valid;
  assign take      = accept && !fifo_empty;
  assign starve    = accept && fifo_empty;
  assign push_drop = bus.ref_valid && fifo_full;

  assign err_bits = sliced ^ fifo_head;
  assign err_inc  = {1'b0, err_bits[0]} + {1'b0, err_bits[1]};
  assign err_sum  = {1'b0, err_count} + (CNT_W+1)'(err_inc);
  assign sym_next = sym_count + CNT_W'(1);

  assign bus.ref_ready = (fifo_count < DEPTH_C);
  assign bus.dec_valid = dec_valid_q;
  assign bus.dec_bits  = dec_bits_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign state_dbg     = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: the run ends on the edge that records the last symbol.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (take && (sym_next == NUM_SYM_C)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Decision output, counters and sticky flags; a flag raised on the
  // start edge survives the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_valid_q <= 1'b0;
      dec_bits_q  <= '0;
      sym_count   <= '0;
      err_count   <= '0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dec_valid_q <= take;
      if (take) dec_bits_q <= sliced;
      if (run_start) begin
        sym_count <= '0;
        err_count <= '0;
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end
      if (take) begin
        sym_count <= sym_next;
        err_count <= err_sum[CNT_W] ? ERR_MAX : err_sum[CNT_W-1:0];
      end
      if (starve)    underflow <= 1'b1;
      if (push_drop) overflow  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qpsk_slicer_ber.sv
// Bench for qpsk_slicer_ber: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a decision scoreboard.
module tb_qpsk_slicer_ber;
  import awgn_pkg::*;

  localparam int NS = 4;
  localparam int FD = 16;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] sym_count, err_count;
  logic          busy, done, underflow, overflow;
  ber_state_t    state_dbg;

  qpsk_slicer_ber_if #(.BI(BI)) bus();

  qpsk_slicer_ber #(.NUM_SYMBOLS(NS), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .sym_count (sym_count),
    .err_count (err_count),
    .busy      (busy),
    .done      (done),
    .underflow (underflow),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every decision pulse must match the oldest expected decision.
  always @(negedge clk) begin
    if (bus.dec_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dec_unexpected: got dec_bits %0h with no decision expected at %0t",
                 bus.dec_bits, $time);
      end else begin
        check("dec_bits", bus.dec_bits, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  logic [1:0]  m_fifo[$];
  bit          m_run, m_done, m_unf, m_ovf, m_dec;
  longint      m_sym, m_err;
  localparam longint ERR_MAX = (64'd1 << CW) - 1;

  // ---------------- driver ----------------
  task automatic step(input bit st, input bit rv, input logic [1:0] rb,
                      input bit sv, input int yr, input int yi);
    logic signed [BI-1:0] vr, vi;
    logic [1:0] r, s;
    bit was_run, was_full, was_empty;
    ber_state_t m_state;
    vr = BI'(yr);
    vi = BI'(yi);
    start = st;
    bus.ref_valid = rv;
    bus.ref_bits = rb;
    bus.sample_valid = sv;
    bus.y_real = vr;
    bus.y_imag = vi;

    m_dec = 0;
    if (!reset) begin
      m_fifo.delete();
      m_run = 0; m_done = 0; m_sym = 0; m_err = 0; m_unf = 0; m_ovf = 0;
    end else begin
      was_run   = m_run;
      was_full  = (m_fifo.size() >= FD);
      was_empty = (m_fifo.size() == 0);
      if (st && !was_run) begin
        m_run = 1; m_done = 0; m_sym = 0; m_err = 0; m_unf = 0; m_ovf = 0;
      end
      if (was_run && sv) begin
        if (!was_empty) begin
          r = m_fifo.pop_front();
          s = {(vi < 0), (vr < 0)};
          exp_q.push_back(s);
          m_dec = 1;
          m_sym++;
          m_err += $countones(s ^ r);
          if (m_err > ERR_MAX) m_err = ERR_MAX;
          if (m_sym == NS) begin m_run = 0; m_done = 1; end
        end else begin
          m_unf = 1;
        end
      end
      if (rv) begin
        if (was_full) m_ovf = 1;
        else m_fifo.push_back(rb);
      end
    end

    @(posedge clk);
    #1;
    start = 0;
    bus.ref_valid = 0;
    bus.sample_valid = 0;

    m_state = m_run ? RUN : (m_done ? DONE : IDLE);
    check("sym_count", sym_count, m_sym);
    check("err_count", err_count, m_err);
    check("underflow", underflow, m_unf);
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("ref_ready", bus.ref_ready, m_fifo.size() < FD);
    check("dec_valid", bus.dec_valid, m_dec);
    check("state", state_dbg, m_state);
  endtask

  task automatic idle();                       step(0, 0, 2'b00, 0, 0, 0);   endtask
  task automatic go();                         step(1, 0, 2'b00, 0, 0, 0);   endtask
  task automatic push(input logic [1:0] b);    step(0, 1, b, 0, 0, 0);       endtask
  task automatic samp(input int yr, input int yi); step(0, 0, 2'b00, 1, yr, yi); endtask

  // Sample whose hard decision equals the given bit pair.
  function automatic int rail(input bit neg);
    return neg ? -37 : 37;
  endfunction

  initial begin
    bus.ref_valid = 0; bus.ref_bits = 0; bus.sample_valid = 0;
    bus.y_real = 0; bus.y_imag = 0;

    // Reset state
    reset = 0;
    repeat (3) idle();
    check("rst_ref_ready", bus.ref_ready, 1);
    check("rst_dec_valid", bus.dec_valid, 0);
    check("rst_sym", sym_count, 0);
    reset = 1;
    idle();

    // Basic run: four symbols, no errors
    push(2'b00); push(2'b01); push(2'b10); push(2'b11);
    go();
    samp(100, 100); samp(-5, 7); samp(1, -1);
    check("tp1_done_before_last", done, 0);
    samp(-9, -9);
    check("tp1_done", done, 1);
    check("tp1_sym", sym_count, 4);
    check("tp1_err", err_count, 0);
    idle();

    // Error counting, then reset in the middle of the run
    push(2'b00); push(2'b01);
    go();
    samp(-1, -1);
    check("tp2_err2", err_count, 2);
    samp(0, 0);
    check("tp2_err3", err_count, 3);
    check("tp2_sym", sym_count, 2);
    push(2'b10);
    reset = 0;
    idle();
    check("tp6_rst_busy", busy, 0);
    check("tp6_rst_sym", sym_count, 0);
    check("tp6_rst_ready", bus.ref_ready, 1);
    reset = 1;

    // Underflow: FIFO empty after the flush
    go();
    samp(5, 5);
    check("tp3_unf", underflow, 1);
    check("tp3_sym", sym_count, 0);
    check("tp3_dec_valid", bus.dec_valid, 0);
    for (int i = 0; i < NS; i++) push(2'(i));
    for (int i = 0; i < NS; i++) samp(rail(i[0]), rail(i[1]));
    check("tp3_done", done, 1);
    go();
    check("tp3_unf_cleared", underflow, 0);

    // Overflow: 17 pushes into a depth-16 FIFO
    for (int i = 0; i < FD + 1; i++) begin
      push(2'(i));
      if (i == FD - 1) check("tp4_ready_full", bus.ref_ready, 0);
    end
    check("tp4_ovf", overflow, 1);
    for (int run = 0; run < FD / NS; run++) begin
      if (run != 0) go();
      for (int i = 0; i < NS; i++) samp(rail(i[0]), rail(i[1]));
      check("tp4_order_err", err_count, 0);
    end

    // Simultaneous push and pop with three entries queued
    go();
    push(2'b01); push(2'b10); push(2'b11);
    step(0, 1, 2'b00, 1, rail(1), rail(0));
    check("tp5_err", err_count, 0);
    samp(rail(0), rail(1)); samp(rail(1), rail(1)); samp(rail(0), rail(0));
    check("tp5_done", done, 1);
    check("tp5_err_final", err_count, 0);
    check("tp5_no_unf", underflow, 0);
    go();
    samp(1, 1);
    check("tp5_fifo_drained", underflow, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit st, rv, sv;
      int yr, yi;
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      st = ($urandom_range(0, 15) == 0);
      rv = ($urandom_range(0, 1) == 1);
      sv = ($urandom_range(0, 1) == 1);
      yr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom);
      yi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom);
      step(st, rv, 2'($urandom_range(0, 3)), sv, yr, yi);
    end
    reset = 1;
    idle(); idle();
    check("drain_exp_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
